uart_rx_framed: RTL
===================

UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 The block SHALL have parameter OVERSAMPLING, default 8: divpulse_in ticks per bit; even, >= 4.
REQ-002 The block SHALL have parameter DATA_BITS, default 8: data bits per frame, 5..9.
REQ-003 The block SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 The block SHALL have parameter STOP_BITS, default 1: stop bits per frame, 1 or 2.
REQ-005 Port sysclk_in SHALL be an input, 1 bit wide: the single system clock.
REQ-006 Port nrst_in SHALL be an input, 1 bit wide: reset, asynchronous, active-low.
REQ-007 Port divpulse_in SHALL be an input, 1 bit wide: oversampling tick, one sysclk_in cycle wide.
REQ-008 Port rx_serial_in SHALL be an input, 1 bit wide: asynchronous serial line, idle high.
REQ-009 Port rx_data_out SHALL be an output, DATA_BITS wide: received word, LSB first on the line.
REQ-010 Port rx_valid_out SHALL be an output, 1 bit wide: holding register full.
REQ-011 Port rx_ready_in SHALL be an input, 1 bit wide: consumer accepts the word.
REQ-012 Port parity_err_out SHALL be an output, 1 bit wide: parity mismatch, qualified by rx_valid_out.
REQ-013 Port frame_err_out SHALL be an output, 1 bit wide: stop bit sampled low, qualified by rx_valid_out.
REQ-014 Port overrun_out SHALL be an output, 1 bit wide: one-cycle pulse when a completed frame is dropped.
REQ-015 Port break_out SHALL be an output, 1 bit wide: one-cycle pulse on a break condition.
REQ-016 Port busy_out SHALL be an output, 1 bit wide: high when the state is not IDLE.

Function
REQ-017 rx_serial_in SHALL pass through a 2-flop synchronizer before any use.
REQ-018 States SHALL be IDLE, START, DATA, PARITY (present only when PARITY != 0), STOP and BREAK_WAIT.
REQ-019 IDLE -> START SHALL occur on a synchronized high-to-low edge, with the tick counter cleared to 0.
REQ-020 Each bit SHALL be sampled on ticks OS/2-1, OS/2 and OS/2+1, and the bit value SHALL be the 2-of-3 majority.
REQ-021 Non-stop bits SHALL advance state on tick OS-1.
REQ-022 A START majority of 1 SHALL be treated as a false start and return to IDLE, with no output activity.
REQ-023 DATA SHALL shift DATA_BITS bits LSB first; PARITY SHALL compare the sampled bit against the even or odd parity of the data.
REQ-024 Each stop bit SHALL be decided at tick OS/2+1; any stop bit low SHALL set the frame error.
REQ-025 After the last stop bit, the FSM SHALL go to IDLE in the same cycle so back-to-back frames are accepted.
REQ-026 Frame completion SHALL load the holding register (data, parity_err, frame_err) and set rx_valid_out on the next cycle.
REQ-027 rx_valid_out SHALL hold until a cycle with rx_valid_out and rx_ready_in both high, then clear.
REQ-028 If a completion coincides with a handshake in the same cycle, the new word SHALL be loaded and rx_valid_out SHALL stay high.
REQ-029 If a completion occurs while rx_valid_out is high and rx_ready_in is low, the new word SHALL be dropped, the old word kept, and overrun_out pulsed.
REQ-030 With PARITY = 0, parity_err_out SHALL be constant 0.

Reset
REQ-031 Asserting nrst_in SHALL force IDLE, counters to 0, and synchronizer flops to 1.
REQ-032 Asserting nrst_in SHALL force rx_data_out to 0 and all flag outputs to 0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame, producing no rx_valid_out or overrun_out after release.

Configuration
REQ-034 With UART_RX_BREAK_DETECT_EN defined, a frame whose start, data, parity and stop bits are all 0 SHALL pulse break_out, SHALL NOT load the holding register, and SHALL enter BREAK_WAIT.
REQ-035 BREAK_WAIT SHALL exit to IDLE once the line has been high for OVERSAMPLING consecutive ticks.
REQ-036 Without UART_RX_BREAK_DETECT_EN, break_out SHALL be tied 0, BREAK_WAIT SHALL be absent, and a break frame SHALL be delivered as data 0 with frame_err_out = 1.

Structure
REQ-037 Package uart_pkg SHALL hold the parity_t enum (NONE/EVEN/ODD), the rx_state_t enum, and the MAJ_LO/MAJ_MID/MAJ_HI sample-tick offsets.
REQ-038 Sub-module uart_rx_sampler SHALL contain the synchronizer, the tick counter and the 2-of-3 majority vote, and SHALL output bit_value plus a bit_done strobe.

Verification
REQ-039 With OS=8, 8N1, send 0xA5 with rx_ready_in low: rx_data_out = 0xA5, rx_valid_out high until ready, both error flags 0.
REQ-040 With PARITY=1, send 0x03 with parity bit 1: rx_valid_out high with parity_err_out = 1 and data 0x03.
REQ-041 Drive a low glitch of 2 ticks, then high: FSM returns to IDLE and rx_valid_out never asserts.
REQ-042 Send 0x11 then 0x22 with rx_ready_in held low: overrun_out pulses once, rx_data_out stays 0x11.
REQ-043 With STOP_BITS=2, send 0x5A with the second stop bit low: frame_err_out = 1 and data 0x5A.
REQ-044 Hold the line low for 12 bit times with the macro defined: one break_out pulse, no rx_valid_out, IDLE one bit time after the line returns high.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the framed UART receiver.
//   parity_t   - parity mode encoding (NONE/EVEN/ODD), matches the PARITY parameter
//   rx_state_t - receiver FSM state encoding
//   MAJ_*      - sample-tick offsets around the bit centre (OVERSAMPLING/2)
//   maj3       - 2-of-3 majority vote
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_t;

  localparam int MAJ_LO  = -1;
  localparam int MAJ_MID = 0;
  localparam int MAJ_HI  = 1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: line synchronizer, oversampling tick counter and 2-of-3 vote.
//   sysclk_in, nrst_in - clock, async active-low reset
//   divpulse_in        - oversampling tick
//   rx_serial_in       - raw serial line
//   cnt_clr_in         - holds the tick counter at 0
//   rx_sync_out        - synchronized line
//   bit_value_out      - majority of the three centre samples (valid at vote/bit strobes)
//   vote_done_out      - strobe on the last centre sample tick (OS/2+1)
//   bit_done_out       - strobe on the last tick of the bit (OS-1)
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLING = 8
) (
  input  logic sysclk_in,
  input  logic nrst_in,
  input  logic divpulse_in,
  input  logic rx_serial_in,
  input  logic cnt_clr_in,
  output logic rx_sync_out,
  output logic bit_value_out,
  output logic vote_done_out,
  output logic bit_done_out
);

  localparam int CNT_W = $clog2(OVERSAMPLING);
  localparam logic [CNT_W-1:0] T_LO  = CNT_W'(OVERSAMPLING / 2 + MAJ_LO);
  localparam logic [CNT_W-1:0] T_MID = CNT_W'(OVERSAMPLING / 2 + MAJ_MID);
  localparam logic [CNT_W-1:0] T_HI  = CNT_W'(OVERSAMPLING / 2 + MAJ_HI);
  localparam logic [CNT_W-1:0] T_END = CNT_W'(OVERSAMPLING - 1);

  logic sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] smp_q, smp_d;
  logic tick_lo, tick_mid, tick_hi, tick_end;

  always_comb begin
    tick_lo  = divpulse_in && (cnt_q == T_LO);
    tick_mid = divpulse_in && (cnt_q == T_MID);
    tick_hi  = divpulse_in && (cnt_q == T_HI);
    tick_end = divpulse_in && (cnt_q == T_END);

    cnt_d = cnt_q;
    if (cnt_clr_in) begin
      cnt_d = '0;
    end else if (divpulse_in) begin
      cnt_d = tick_end ? '0 : cnt_q + CNT_W'(1);
    end

    smp_d = smp_q;
    if (tick_lo)  smp_d[0] = sync2_q;
    if (tick_mid) smp_d[1] = sync2_q;
    if (tick_hi)  smp_d[2] = sync2_q;
  end

  // The third sample is used live on its own tick so the vote is ready then.
  assign bit_value_out = maj3(smp_q[0], smp_q[1], tick_hi ? sync2_q : smp_q[2]);
  assign vote_done_out = tick_hi;
  assign bit_done_out  = tick_end;
  assign rx_sync_out   = sync2_q;

  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      smp_q   <= 3'b111;
    end else begin
      sync1_q <= rx_serial_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      smp_q   <= smp_d;
    end
  end

endmodule

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: oversampling UART receiver with holding register and error flags.
//   sysclk_in, nrst_in      - clock, async active-low reset
//   divpulse_in             - oversampling tick (OVERSAMPLING per bit)
//   rx_serial_in            - serial line, idle high
//   rx_data_out/rx_valid_out/rx_ready_in - holding register and handshake
//   parity_err_out, frame_err_out        - word flags, qualified by rx_valid_out
//   overrun_out, break_out  - one-cycle event pulses
//   busy_out                - FSM not idle
// Optional: UART_RX_BREAK_DETECT_EN enables break detection and BREAK_WAIT.
//
// state         | meaning
// ST_IDLE       | waiting for falling edge, tick counter held at 0
// ST_START      | verifying start bit; majority 1 is a false start
// ST_DATA       | shifting DATA_BITS bits LSB first
// ST_PARITY     | checking parity bit (PARITY != 0 only)
// ST_STOP       | deciding stop bit(s) at the centre vote
// ST_BREAK_WAIT | after a break, waiting for OVERSAMPLING high ticks
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int OVERSAMPLING = 8,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 sysclk_in,
  input  logic                 nrst_in,
  input  logic                 divpulse_in,
  input  logic                 rx_serial_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_valid_out,
  input  logic                 rx_ready_in,
  output logic                 parity_err_out,
  output logic                 frame_err_out,
  output logic                 overrun_out,
  output logic                 break_out,
  output logic                 busy_out
);

  localparam parity_t PAR_MODE = parity_t'(PARITY);
  localparam int BIT_W = 4;

  logic rx_sync, bit_value, vote_done, bit_done, cnt_clr, complete;
  rx_state_t state_q, state_d;
  logic prev_q;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_hold_q, data_hold_d;
  logic zero_q, zero_d, ferr_q, ferr_d, perr_q, perr_d;
  logic valid_q, valid_d, perr_hold_q, perr_hold_d, ferr_hold_q, ferr_hold_d;
  logic overrun_q, overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
  logic break_q, break_d;
  assign break_out = break_q;
`else
  assign break_out = 1'b0;
`endif

  uart_rx_sampler #(.OVERSAMPLING(OVERSAMPLING)) u_sampler (
    .sysclk_in    (sysclk_in),
    .nrst_in      (nrst_in),
    .divpulse_in  (divpulse_in),
    .rx_serial_in (rx_serial_in),
    .cnt_clr_in   (cnt_clr),
    .rx_sync_out  (rx_sync),
    .bit_value_out(bit_value),
    .vote_done_out(vote_done),
    .bit_done_out (bit_done)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    zero_d     = zero_q;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    complete   = 1'b0;
    cnt_clr    = (state_q == ST_IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
    break_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (prev_q && !rx_sync) begin
          state_d = ST_START;
          zero_d  = 1'b1;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
        end
      end
      ST_START: begin
        if (vote_done && bit_value) begin
          state_d = ST_IDLE;
        end else if (bit_done) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = {bit_value, shift_q[DATA_BITS-1:1]};
          if (bit_value) zero_d = 1'b0;
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            stop_cnt_d = 1'b0;
            state_d    = (PAR_MODE == NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          if (bit_value) zero_d = 1'b0;
          // Even: data plus parity bit must have even weight; odd flips the sense.
          perr_d     = (^shift_q) ^ bit_value ^ (PAR_MODE == ODD);
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (vote_done) begin
          if (!bit_value) ferr_d = 1'b1;
          if (bit_value) zero_d = 1'b0;
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            state_d  = ST_IDLE;
            complete = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
            if (zero_q && !bit_value) begin
              state_d  = ST_BREAK_WAIT;
              complete = 1'b0;
              break_d  = 1'b1;
              cnt_clr  = 1'b1;
            end
`endif
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
`ifdef UART_RX_BREAK_DETECT_EN
      ST_BREAK_WAIT: begin
        // Counter restarts on every low sample, so wrap means OS consecutive high ticks.
        cnt_clr = !rx_sync;
        if (bit_done && rx_sync) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    data_hold_d = data_hold_q;
    perr_hold_d = perr_hold_q;
    ferr_hold_d = ferr_hold_q;
    overrun_d   = 1'b0;
    valid_d     = valid_q && !rx_ready_in;
    if (complete) begin
      if (!valid_q || rx_ready_in) begin
        data_hold_d = shift_q;
        perr_hold_d = (PAR_MODE != NONE) && perr_d;
        ferr_hold_d = ferr_d;
        valid_d     = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state_q     <= ST_IDLE;
      prev_q      <= 1'b1;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      shift_q     <= '0;
      zero_q      <= 1'b0;
      ferr_q      <= 1'b0;
      perr_q      <= 1'b0;
      data_hold_q <= '0;
      perr_hold_q <= 1'b0;
      ferr_hold_q <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
      break_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      prev_q      <= rx_sync;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      zero_q      <= zero_d;
      ferr_q      <= ferr_d;
      perr_q      <= perr_d;
      data_hold_q <= data_hold_d;
      perr_hold_q <= perr_hold_d;
      ferr_hold_q <= ferr_hold_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
      break_q     <= break_d;
`endif
    end
  end

  assign rx_data_out    = data_hold_q;
  assign rx_valid_out   = valid_q;
  assign parity_err_out = perr_hold_q;
  assign frame_err_out  = ferr_hold_q;
  assign overrun_out    = overrun_q;
  assign busy_out       = (state_q != ST_IDLE);

endmodule
